// File: rtl/scope_filter_pkg.sv
// Shared types, register map and CTL bit positions for the scope filter coefficient controller.
package scope_filter_pkg;
  typedef logic signed [17:0] coef_aa_t;
  typedef logic signed [24:0] coef_t;

  typedef struct packed {
    coef_aa_t aa;
    coef_t    bb;
    coef_t    kk;
    coef_t    pp;
  } scope_filter_cfg_t;

  localparam logic [2:0] ADDR_AA  = 3'd0;
  localparam logic [2:0] ADDR_BB  = 3'd1;
  localparam logic [2:0] ADDR_KK  = 3'd2;
  localparam logic [2:0] ADDR_PP  = 3'd3;
  localparam logic [2:0] ADDR_CTL = 3'd4;

  localparam int CTL_COMMIT  = 0;
  localparam int CTL_FLUSH   = 1;
  localparam int CTL_CLR_ERR = 2;
  localparam int CTL_BUSY    = 8;
  localparam int CTL_DIFF    = 9;
  localparam int CTL_ERR     = 10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GATE, ST_DRAIN, ST_LOAD, ST_FLUSH, ST_RELEASE
  } ctl_state_t;
endpackage

// File: rtl/scope_filter_ctl_regs.sv
// Shadow coefficient registers, bus decode/readback and the sticky write-while-busy error flag.
module scope_filter_ctl_regs
  import scope_filter_pkg::*;
#(
  parameter coef_aa_t AA_RST = 18'sd0,
  parameter coef_t    BB_RST = 25'sd0,
  parameter coef_t    KK_RST = 25'h0FFFFFF,
  parameter coef_t    PP_RST = 25'sd0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              bus_wen,
  input  logic              bus_ren,
  input  logic [2:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic              i_busy,
  input  scope_filter_cfg_t i_active,
  output scope_filter_cfg_t o_shadow,
  output logic              o_commit,
  output logic              o_flush
);
  scope_filter_cfg_t r_shadow;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rdata;
  logic              w_coef_wr, w_ctl_wr, w_clr, w_err_set, w_diff;

  assign w_coef_wr = bus_wen && (bus_addr[2] == 1'b0);
  assign w_ctl_wr  = bus_wen && (bus_addr == ADDR_CTL);
  assign w_clr     = w_ctl_wr && bus_wdata[CTL_CLR_ERR];
  assign w_err_set = i_busy && (w_coef_wr || (w_ctl_wr && bus_wdata[CTL_COMMIT]));
  assign w_diff    = (r_shadow != i_active);
  assign o_commit  = w_ctl_wr && bus_wdata[CTL_COMMIT] && !i_busy;
  assign o_flush   = bus_wdata[CTL_FLUSH];
  assign o_shadow  = r_shadow;
  assign bus_rdata = r_rdata;

  always_comb begin
    w_rdata = '0;
    case (bus_addr)
      ADDR_AA:  w_rdata = {{14{r_shadow.aa[17]}}, r_shadow.aa};
      ADDR_BB:  w_rdata = {{7{r_shadow.bb[24]}}, r_shadow.bb};
      ADDR_KK:  w_rdata = {{7{r_shadow.kk[24]}}, r_shadow.kk};
      ADDR_PP:  w_rdata = {{7{r_shadow.pp[24]}}, r_shadow.pp};
      ADDR_CTL: begin
        w_rdata[CTL_BUSY] = i_busy;
        w_rdata[CTL_DIFF] = w_diff;
        w_rdata[CTL_ERR]  = r_err;
      end
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow <= '{aa: AA_RST, bb: BB_RST, kk: KK_RST, pp: PP_RST};
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (bus_ren) r_rdata <= w_rdata;
      if (w_coef_wr && !i_busy) begin
        case (bus_addr)
          ADDR_AA: r_shadow.aa <= bus_wdata[17:0];
          ADDR_BB: r_shadow.bb <= bus_wdata[24:0];
          ADDR_KK: r_shadow.kk <= bus_wdata[24:0];
          default: r_shadow.pp <= bus_wdata[24:0];
        endcase
      end
      // Clear is applied before a same-write rejected commit can re-set the flag.
      r_err <= (r_err && !w_clr) || w_err_set;
    end
  end
endmodule

// File: rtl/scope_filter_ctl.sv
// Commit sequencer: gates filter input, drains the pipeline, swaps shadow into active, optional flush reset.
module scope_filter_ctl
  import scope_filter_pkg::*;
#(
  parameter int       PIPE_LAT = 4,
  parameter int       RST_LEN  = 2,
  parameter coef_aa_t AA_RST   = 18'sd0,
  parameter coef_t    BB_RST   = 25'sd0,
  parameter coef_t    KK_RST   = 25'h0FFFFFF,
  parameter coef_t    PP_RST   = 25'sd0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               bus_wen,
  input  logic               bus_ren,
  input  logic [2:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  input  logic               sto_tready,
  output logic signed [17:0] cfg_aa,
  output logic signed [24:0] cfg_bb,
  output logic signed [24:0] cfg_kk,
  output logic signed [24:0] cfg_pp,
  output logic               ctl_rst,
  output logic               in_gate,
  output logic               busy,
  output logic               done
);
  localparam int CNT_W = 8;

  ctl_state_t        r_state;
  scope_filter_cfg_t r_active;
  scope_filter_cfg_t w_shadow;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flush_req, r_ctl_rst, r_in_gate, r_busy, r_done;
  logic              w_commit, w_flush;

  scope_filter_ctl_regs #(
    .AA_RST(AA_RST), .BB_RST(BB_RST), .KK_RST(KK_RST), .PP_RST(PP_RST)
  ) u_regs (
    .clk      (clk),
    .rstn     (rstn),
    .bus_wen  (bus_wen),
    .bus_ren  (bus_ren),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .i_busy   (r_busy),
    .i_active (r_active),
    .o_shadow (w_shadow),
    .o_commit (w_commit),
    .o_flush  (w_flush)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_active    <= '{aa: AA_RST, bb: BB_RST, kk: KK_RST, pp: PP_RST};
      r_cnt       <= '0;
      r_flush_req <= 1'b0;
      r_ctl_rst   <= 1'b0;
      r_in_gate   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_commit) begin
          r_state     <= ST_GATE;
          r_in_gate   <= 1'b1;
          r_busy      <= 1'b1;
          r_flush_req <= w_flush;
        end
        ST_GATE: begin
          r_state <= ST_DRAIN;
          r_cnt   <= CNT_W'(PIPE_LAT);
        end
        // Only cycles where the output is accepted retire a pipeline stage.
        ST_DRAIN: begin
          if (r_cnt == '0) r_state <= ST_LOAD;
          else if (sto_tready) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_active <= w_shadow;
          if (r_flush_req) begin
            r_state   <= ST_FLUSH;
            r_ctl_rst <= 1'b1;
            r_cnt     <= CNT_W'(RST_LEN);
          end else begin
            r_state   <= ST_RELEASE;
            r_in_gate <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state   <= ST_RELEASE;
            r_ctl_rst <= 1'b0;
            r_in_gate <= 1'b0;
            r_done    <= 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_in_gate <= 1'b0;
          r_ctl_rst <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_aa  = r_active.aa;
  assign cfg_bb  = r_active.bb;
  assign cfg_kk  = r_active.kk;
  assign cfg_pp  = r_active.pp;
  assign ctl_rst = r_ctl_rst;
  assign in_gate = r_in_gate;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule

// File: tb/tb_scope_filter_ctl.sv
// Directed and random bench for scope_filter_ctl against an event-timeline reference model.
module tb_scope_filter_ctl;
  import scope_filter_pkg::*;
  localparam int PIPE_LAT = 4;
  localparam int RST_LEN  = 2;

  logic clk = 0, rstn = 0;
  logic bus_wen = 0, bus_ren = 0, sto_tready = 1;
  logic [2:0] bus_addr = 0;
  logic [31:0] bus_wdata = 0, bus_rdata;
  logic signed [17:0] cfg_aa;
  logic signed [24:0] cfg_bb, cfg_kk, cfg_pp;
  logic ctl_rst, in_gate, busy, done;

  always #5 clk = ~clk;

  scope_filter_ctl #(.PIPE_LAT(PIPE_LAT), .RST_LEN(RST_LEN)) dut (
    .clk(clk), .rstn(rstn), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .sto_tready(sto_tready),
    .cfg_aa(cfg_aa), .cfg_bb(cfg_bb), .cfg_kk(cfg_kk), .cfg_pp(cfg_pp),
    .ctl_rst(ctl_rst), .in_gate(in_gate), .busy(busy), .done(done));

  int n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(logic [31:0] v, int w);
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    return v[w-1] ? (v | ~m) : (v & m);
  endfunction

  // Model: register file as arrays; a commit is a timeline of edge indices.
  logic [31:0] m_sh[4], m_ac[4], m_rdata;
  bit m_busy, m_flush, m_err;
  int m_n, m_commit, m_load, m_rel, m_trcnt;
  int widths[4] = '{18, 25, 25, 25};

  task automatic m_reset();
    m_sh = '{32'h0, 32'h0, 32'h0FFFFFF, 32'h0};
    m_ac = m_sh;
    m_rdata = 0; m_busy = 0; m_flush = 0; m_err = 0;
    m_n = 0; m_commit = -100; m_load = -1; m_rel = -1; m_trcnt = 0;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_reset();
    else begin
      bit busy0, diff;
      busy0 = m_busy;
      m_n++;
      diff = (m_sh != m_ac);
      if (bus_ren) begin
        if (bus_addr < 4) m_rdata = m_sh[bus_addr];
        else if (bus_addr == 4) m_rdata = (32'(m_err) << 10) | (32'(diff) << 9) | (32'(m_busy) << 8);
        else m_rdata = 0;
      end
      if (bus_wen && bus_addr < 4) begin
        if (busy0) m_err = 1;
        else m_sh[bus_addr] = sext(bus_wdata, widths[bus_addr]);
      end else if (bus_wen && bus_addr == 4) begin
        if (bus_wdata[2]) m_err = 0;
        if (bus_wdata[0]) begin
          if (busy0) m_err = 1;
          else begin
            m_busy = 1; m_commit = m_n; m_flush = bus_wdata[1];
            m_trcnt = 0; m_load = -1; m_rel = -1;
          end
        end
      end
      if (busy0) begin
        // Drain counts accepted outputs starting two edges after the commit edge.
        if (m_load < 0 && m_n >= m_commit + 2 && sto_tready) begin
          m_trcnt++;
          if (m_trcnt == PIPE_LAT) m_load = m_n + 1;
        end
        if (m_n == m_load) begin
          m_ac = m_sh;
          m_rel = m_n + (m_flush ? RST_LEN : 0);
        end
        if (m_rel >= 0 && m_n == m_rel + 1) m_busy = 0;
      end
    end
  end

  task automatic check_all();
    bit e_gate, e_done, e_rst;
    e_gate = m_busy && !(m_rel >= 0 && m_n >= m_rel);
    e_done = m_busy && m_rel >= 0 && m_n == m_rel;
    e_rst  = m_busy && m_flush && m_load >= 0 && m_n >= m_load && m_n < m_rel;
    chk("cfg_aa", sext(32'(cfg_aa), 18), m_ac[0]);
    chk("cfg_bb", sext(32'(cfg_bb), 25), m_ac[1]);
    chk("cfg_kk", sext(32'(cfg_kk), 25), m_ac[2]);
    chk("cfg_pp", sext(32'(cfg_pp), 25), m_ac[3]);
    chk("in_gate", 32'(in_gate), 32'(e_gate));
    chk("ctl_rst", 32'(ctl_rst), 32'(e_rst));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("rdata", bus_rdata, m_rdata);
  endtask

  task automatic drive(bit wen, bit ren, logic [2:0] a, logic [31:0] d, bit tr);
    @(negedge clk);
    check_all();
    bus_wen = wen; bus_ren = ren; bus_addr = a; bus_wdata = d; sto_tready = tr;
  endtask

  task automatic idle(bit tr = 1); drive(0, 0, 0, 0, tr); endtask
  task automatic wr(logic [2:0] a, logic [31:0] d); drive(1, 0, a, d, 1); endtask
  task automatic rd(logic [2:0] a); drive(0, 1, a, 0, 1); endtask

  // Commit, stall tready on drive calls lo..hi, and return edges from write to new cfg_bb.
  task automatic timed_commit(logic [24:0] bb, int lo, int hi, output int lat);
    int c;
    wr(ADDR_BB, 32'(bb));
    wr(ADDR_CTL, 32'h1);
    c = 0;
    while (cfg_bb !== bb && c < 30) begin
      c++;
      idle(!(c >= lo && c <= hi));
    end
    lat = c - 1;
  endtask

  initial begin
    int lat, hi_cnt, done_cnt;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    rstn = 1;
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(); idle();

    timed_commit(25'h0012345, 0, -1, lat);
    chk("latency_nostall", 32'(lat), 32'd6);
    repeat (3) idle();
    timed_commit(25'h1ABCDEF, 4, 6, lat);
    chk("latency_stall", 32'(lat), 32'd9);
    repeat (3) idle();

    wr(ADDR_PP, 32'hFFFF_F00D);
    wr(ADDR_CTL, 32'h3);
    hi_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      idle();
      hi_cnt += int'(ctl_rst);
      done_cnt += int'(done);
    end
    chk("flush_len", 32'(hi_cnt), 32'(RST_LEN));
    chk("flush_done", 32'(done_cnt), 32'd1);

    wr(ADDR_CTL, 32'h1);
    wr(ADDR_AA, 32'h0001_1111);
    wr(ADDR_CTL, 32'h1);
    for (int i = 0; i < 30 && busy; i++) idle();
    chk("busy_cleared", 32'(busy), 32'd0);
    rd(ADDR_AA); rd(ADDR_CTL); idle();
    chk("err_bit", 32'(bus_rdata[CTL_ERR]), 32'd1);
    wr(ADDR_CTL, 32'h4); rd(ADDR_CTL); idle();
    chk("err_clr", 32'(bus_rdata[CTL_ERR]), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 2) == 0) ? ADDR_CTL : 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == ADDR_CTL) d = {29'h0, ($urandom_range(0, 5) == 0), d[1], ($urandom_range(0, 3) != 0)};
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, d, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 30 && busy; i++) idle();

    wr(ADDR_KK, 32'h0000_0123);
    wr(ADDR_CTL, 32'h1);
    repeat (4) idle();
    #2 rstn = 0;
    #1;
    chk("rst_in_gate", 32'(in_gate), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctl_rst", 32'(ctl_rst), 32'd0);
    chk("rst_kk", 32'(cfg_kk), 32'h0FFFFFF);
    chk("rst_bb", 32'(cfg_bb), 32'd0);
    @(negedge clk);
    check_all();
    rstn = 1;
    rd(ADDR_KK); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
